// File: rtl/exp_irq_ctrl.sv
// Exception/interrupt request controller ahead of CP0. It captures rising edges
// into pending bits, applies a software mask, and issues a fixed-priority take and vector.
module exp_irq_ctrl #(
   parameter int unsigned N        = 3,
   parameter int unsigned CW       = 2,
   parameter logic [31:0] VEC_BASE = 32'h0000_0040
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  src_in,
   input  logic          mask_we,
   input  logic [N-1:0]  mask_din,
   input  logic [31:0]   pc_cur,
   input  logic          eret,
   output logic          exp_take,
   output logic [31:0]   vec_pc,
   output logic [31:0]   epc_out,
   output logic [CW-1:0] cause,
   output logic          in_service,
   output logic [N-1:0]  pending,
   output logic [N-1:0]  mask
);

   typedef enum logic [1:0] {IDLE, TAKE, SERVICE} state_t;

   state_t        state;
   logic [N-1:0]  src_q;
   logic [N-1:0]  rise;
   logic [N-1:0]  eligible;
   logic [N-1:0]  clr;
   logic [CW-1:0] sel;
   logic          found;

   // Only IDLE arbitrates, so clr is nonzero exactly on an IDLE->TAKE edge.
   always_comb begin
      rise     = src_in & ~src_q;
      eligible = pending & ~mask;
      sel      = '0;
      clr      = '0;
      found    = 1'b0;
      if (state == IDLE) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (eligible[i] && !found) begin
               found  = 1'b1;
               sel    = CW'(i);
               clr[i] = 1'b1;
            end
         end
      end
   end

   assign vec_pc = VEC_BASE + 32'({cause, 2'b00});

   // Set beats clear: a new rise on the source being taken keeps it pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pending    <= '0;
         mask       <= '0;
         src_q      <= '0;
         cause      <= '0;
         epc_out    <= '0;
         exp_take   <= 1'b0;
         in_service <= 1'b0;
      end else begin
         src_q    <= src_in;
         pending  <= (pending & ~clr) | rise;
         exp_take <= 1'b0;
         if (mask_we)
            mask <= mask_din;
         case (state)
            IDLE: begin
               if (found) begin
                  state      <= TAKE;
                  cause      <= sel;
                  epc_out    <= pc_cur;
                  exp_take   <= 1'b1;
                  in_service <= 1'b1;
               end
            end
            TAKE: begin
               state <= SERVICE;
            end
            SERVICE: begin
               if (eret) begin
                  state      <= IDLE;
                  in_service <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               in_service <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exp_irq_ctrl.sv
// Bench for exp_irq_ctrl: a behavioural model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_exp_irq_ctrl;

   localparam int unsigned N  = 3;
   localparam int unsigned CW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  src_in;
   logic          mask_we;
   logic [N-1:0]  mask_din;
   logic [31:0]   pc_cur;
   logic          eret;
   logic          exp_take;
   logic [31:0]   vec_pc;
   logic [31:0]   epc_out;
   logic [CW-1:0] cause;
   logic          in_service;
   logic [N-1:0]  pending;
   logic [N-1:0]  mask;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   exp_irq_ctrl #(.N(N), .CW(CW), .VEC_BASE(32'h0000_0040)) dut (
      .clk(clk), .rst(rst), .src_in(src_in), .mask_we(mask_we),
      .mask_din(mask_din), .pc_cur(pc_cur), .eret(eret),
      .exp_take(exp_take), .vec_pc(vec_pc), .epc_out(epc_out),
      .cause(cause), .in_service(in_service), .pending(pending), .mask(mask)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a request list, a mask, and two flags (busy serving; take just issued)
   bit          m_pend [N];
   bit          m_mask [N];
   bit          m_last [N];
   bit          m_busy, m_fresh;
   int unsigned m_cause;
   logic [31:0] m_epc;

   always @(posedge clk) begin
      bit rose [N];
      int pick;
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_mask[i] = 0; m_last[i] = 0;
         end
         m_busy = 0; m_fresh = 0; m_cause = 0; m_epc = '0;
      end else begin
         for (int i = 0; i < N; i++) rose[i] = src_in[i] && !m_last[i];
         pick = -1;
         for (int i = N - 1; i >= 0; i--)
            if (m_pend[i] && !m_mask[i]) pick = i;
         if (!m_busy && pick >= 0) begin
            m_busy = 1; m_fresh = 1;
            m_cause = pick; m_epc = pc_cur;
            m_pend[pick] = 0;
         end else if (m_fresh) begin
            m_fresh = 0;
         end else if (m_busy && eret) begin
            m_busy = 0;
         end
         for (int i = 0; i < N; i++) begin
            if (rose[i]) m_pend[i] = 1;
            if (mask_we) m_mask[i] = mask_din[i];
            m_last[i] = src_in[i];
         end
      end
   end

   always @(negedge clk) begin
      logic [N-1:0] pv, mv;
      if (chk_en) begin
         for (int i = 0; i < N; i++) begin
            pv[i] = m_pend[i]; mv[i] = m_mask[i];
         end
         chk("exp_take",   32'(exp_take),   32'(m_fresh));
         chk("in_service", 32'(in_service), 32'(m_busy));
         chk("cause",      32'(cause),      m_cause);
         chk("vec_pc",     vec_pc,          32'h40 + m_cause * 4);
         chk("epc_out",    epc_out,         m_epc);
         chk("pending",    32'(pending),    32'(pv));
         chk("mask",       32'(mask),       32'(mv));
      end
   end

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic eret_then_take();
      eret = 1'b1; step();
      eret = 1'b0; step();
   endtask

   initial begin
      int takes;
      rst = 1'b1; src_in = '0; mask_we = 1'b0; mask_din = '0;
      pc_cur = 32'h0040_0000; eret = 1'b0;
      step(3);
      chk_en = 1'b1;
      chk("rst_pending", 32'(pending), 32'h0);
      chk("rst_take",    32'(exp_take), 32'h0);
      chk("rst_epc",     epc_out, 32'h0);
      rst = 1'b0; step();

      // single pulse on source 1
      src_in = 3'b010; step();
      src_in = 3'b000;
      chk("p1_pending", 32'(pending), 32'h2);
      step();
      chk("p1_take",  32'(exp_take), 32'h1);
      chk("p1_cause", 32'(cause), 32'h1);
      chk("p1_vec",   vec_pc, 32'h0000_0044);
      chk("p1_epc",   epc_out, 32'h0040_0000);
      chk("p1_insvc", 32'(in_service), 32'h1);
      step();
      chk("p1_take_low", 32'(exp_take), 32'h0);
      chk("p1_insvc2",   32'(in_service), 32'h1);
      eret = 1'b1; step(); eret = 1'b0;
      chk("eret_insvc", 32'(in_service), 32'h0);
      chk("eret_epc",   epc_out, 32'h0040_0000);
      step(2);

      // simultaneous requests serviced in index order
      pc_cur = 32'h0040_0100;
      src_in = 3'b111; step();
      src_in = 3'b000; step();
      chk("all_cause0", 32'(cause), 32'h0);
      chk("all_pend",   32'(pending), 32'h6);
      step(2);
      eret_then_take();
      chk("all_cause1", 32'(cause), 32'h1);
      chk("all_take1",  32'(exp_take), 32'h1);
      step();
      eret_then_take();
      chk("all_cause2", 32'(cause), 32'h2);
      chk("all_pend0",  32'(pending), 32'h0);
      step();
      eret = 1'b1; step(); eret = 1'b0; step();

      // masked source held pending until unmasked
      mask_we = 1'b1; mask_din = 3'b100; step();
      mask_we = 1'b0;
      src_in = 3'b100; step();
      src_in = 3'b000;
      takes = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         takes += int'(exp_take);
      end
      chk("mask_notake", takes, 0);
      chk("mask_pend",   32'(pending), 32'h4);
      mask_we = 1'b1; mask_din = 3'b000; step();
      mask_we = 1'b0;
      chk("unmask_same_edge", 32'(exp_take), 32'h0);
      step();
      chk("unmask_take",  32'(exp_take), 32'h1);
      chk("unmask_cause", 32'(cause), 32'h2);
      chk("unmask_vec",   vec_pc, 32'h0000_0048);
      step();
      eret = 1'b1; step(); eret = 1'b0; step();

      // rise on source 1 in the same edge it is taken
      mask_we = 1'b1; mask_din = 3'b010; step();
      mask_we = 1'b0; src_in = 3'b010; step();
      src_in = 3'b000; step();
      mask_we = 1'b1; mask_din = 3'b000; step();
      mask_we = 1'b0; src_in = 3'b010; step();
      chk("same_take", 32'(exp_take), 32'h1);
      chk("same_pend", 32'(pending), 32'h2);
      src_in = 3'b000; step(2);
      src_in = 3'b010; step();
      src_in = 3'b000; step();
      eret_then_take();
      chk("retake_cause", 32'(cause), 32'h1);
      chk("retake_pend",  32'(pending), 32'h0);
      step();

      // reset during service with a source held high through release
      mask_we = 1'b1; mask_din = 3'b010; step();
      mask_we = 1'b0;
      rst = 1'b1; src_in = 3'b001; step();
      chk("mrst_insvc", 32'(in_service), 32'h0);
      chk("mrst_pend",  32'(pending), 32'h0);
      chk("mrst_mask",  32'(mask), 32'h0);
      chk("mrst_epc",   epc_out, 32'h0);
      chk("mrst_take",  32'(exp_take), 32'h0);
      step();
      rst = 1'b0;
      takes = 0;
      for (int i = 0; i < 12; i++) begin
         eret = (i == 4);
         step();
         takes += int'(exp_take);
      end
      eret = 1'b0;
      chk("held_one_take", takes, 1);
      src_in = 3'b000; step(2);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) src_in = N'($urandom_range(0, 7));
         mask_we  = ($urandom_range(0, 15) == 0);
         mask_din = N'($urandom_range(0, 7));
         eret     = ($urandom_range(0, 4) == 0);
         pc_cur   = $urandom;
         rst      = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0; eret = 1'b0; mask_we = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
